// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signal bundle for mem_arbiter.
// The arbiter connects through the slave modport; the cores/memory environment through master.
interface mem_arbiter_if;
    logic [3:0]   c_req;
    logic [3:0]   c_we;
    logic [3:0]   c_lock;
    logic [43:0]  c_addr;
    logic [127:0] c_wdata;
    logic [15:0]  c_opcode;
    logic [127:0] c_burst_id;
    logic [3:0]   c_gnt;
    logic [3:0]   c_rvalid;
    logic [31:0]  c_rdata;

    logic         m_req;
    logic         m_we;
    logic [1:0]   m_core_id;
    logic [3:0]   m_opcode;
    logic [10:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_burst_id;
    logic         m_gnt;
    logic         m_rvalid;
    logic [31:0]  m_rdata;

    logic         busy;
    logic         err;

    modport slave (
        input  c_req, c_we, c_lock, c_addr, c_wdata, c_opcode, c_burst_id,
        input  m_gnt, m_rvalid, m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output m_req, m_we, m_core_id, m_opcode, m_addr, m_wdata, m_burst_id,
        output busy, err
    );

    modport master (
        output c_req, c_we, c_lock, c_addr, c_wdata, c_opcode, c_burst_id,
        output m_gnt, m_rvalid, m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  m_req, m_we, m_core_id, m_opcode, m_addr, m_wdata, m_burst_id,
        input  busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Four-core round-robin arbiter in front of a single-outstanding memory port,
// with locked bursts (bounded by MAX_BURST) and a response timeout.
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]    state, next_state;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;

    logic          any_req;
    logic [1:0]    rr_winner;
    logic          load, relock, complete, timeout;
    logic [1:0]    load_core;
    logic          lock_ok;

    logic          sel_we;
    logic [10:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_opcode;
    logic [31:0]   sel_burst_id;

    // Completion is signalled by m_rvalid alone; m_gnt is accepted but ignored.
    logic unused_m_gnt;
    assign unused_m_gnt = bus.m_gnt;

    // Round-robin: scanning from the farthest offset down leaves the nearest requester to ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rr_winner = ptr;
        any_req   = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.c_req[ptr + 2'(i)]) begin
                rr_winner = ptr + 2'(i);
                any_req   = 1'b1;
            end
        end
    end

    assign lock_ok = bus.c_lock[owner] && bus.c_req[owner] &&
                     (burst_cnt < BW'(MAX_BURST - 1));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        relock     = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        load_core  = rr_winner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load       = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (bus.m_rvalid) begin
                    complete = 1'b1;
                    if (lock_ok) begin
                        relock     = 1'b1;
                        load       = 1'b1;
                        load_core  = owner;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sel_we       = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_opcode   = '0;
        sel_burst_id = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (2'(k) == load_core) begin
                sel_we       = bus.c_we[k];
                sel_addr     = bus.c_addr[k*11 +: 11];
                sel_wdata    = bus.c_wdata[k*32 +: 32];
                sel_opcode   = bus.c_opcode[k*4 +: 4];
                sel_burst_id = bus.c_burst_id[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            burst_cnt      <= '0;
            tmo_cnt        <= '0;
            bus.c_gnt      <= '0;
            bus.c_rvalid   <= '0;
            bus.c_rdata    <= '0;
            bus.m_req      <= 1'b0;
            bus.m_we       <= 1'b0;
            bus.m_core_id  <= '0;
            bus.m_opcode   <= '0;
            bus.m_addr     <= '0;
            bus.m_wdata    <= '0;
            bus.m_burst_id <= '0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state        <= next_state;
            bus.busy     <= (next_state != IDLE);
            bus.c_gnt    <= '0;
            bus.c_rvalid <= '0;
            bus.m_req    <= 1'b0;
            bus.err      <= timeout;
            tmo_cnt      <= (state == WAIT && next_state == WAIT) ? tmo_cnt + 1'b1 : '0;

            if (load) begin
                owner          <= load_core;
                bus.c_gnt      <= 4'b0001 << load_core;
                bus.m_req      <= 1'b1;
                bus.m_core_id  <= load_core;
                bus.m_we       <= sel_we;
                bus.m_addr     <= sel_addr;
                bus.m_wdata    <= sel_wdata;
                bus.m_opcode   <= sel_opcode;
                bus.m_burst_id <= sel_burst_id;
                burst_cnt      <= relock ? burst_cnt + 1'b1 : '0;
            end

            if (complete || timeout) begin
                bus.c_rvalid <= 4'b0001 << owner;
                bus.c_rdata  <= complete ? bus.m_rdata : 32'h0;
                if (!relock) begin
                    ptr       <= owner + 2'd1;
                    burst_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int MB = 8;
    localparam int TO = 15;

    localparam int RSP_ZERO  = 0;
    localparam int RSP_NEVER = 1;
    localparam int RSP_RAND  = 2;

    logic clk;
    logic reset_n;
    mem_arbiter_if bus();

    mem_arbiter #(.NUM_CORES(4), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rsp_mode = RSP_ZERO;
    logic force_rv = 1'b0;
    logic cmp_en = 1'b0;
    logic [31:0] mem [0:2047];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int   m_phase;   // 0 idle, 1 request on the bus, 2 awaiting response
    int   m_owner, m_next, m_txn_in_burst, m_waited;
    logic [3:0]  e_gnt, e_rvalid;
    logic [31:0] e_rdata, e_wdata, e_bid;
    logic        e_mreq, e_we, e_busy, e_err;
    logic [1:0]  e_core;
    logic [3:0]  e_op;
    logic [10:0] e_addr;

    task automatic model_grant(input int w);
        e_gnt   = 4'b0001 << w;
        e_mreq  = 1'b1;
        m_owner = w;
        e_core  = 2'(w);
        e_we    = bus.c_we[w];
        e_addr  = bus.c_addr[w*11 +: 11];
        e_wdata = bus.c_wdata[w*32 +: 32];
        e_op    = bus.c_opcode[w*4 +: 4];
        e_bid   = bus.c_burst_id[w*32 +: 32];
        m_phase = 1;
    endtask

    task automatic model_finish();
        m_next  = (m_owner + 1) % 4;
        m_phase = 0;
    endtask

    task automatic model_step();
        bit found;
        int w;
        if (!reset_n) begin
            m_phase = 0; m_owner = 0; m_next = 0; m_txn_in_burst = 0; m_waited = 0;
            e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_mreq = 1'b0; e_we = 1'b0;
            e_core = '0; e_op = '0; e_addr = '0; e_wdata = '0; e_bid = '0;
            e_busy = 1'b0; e_err = 1'b0;
            return;
        end
        e_gnt = '0; e_rvalid = '0; e_err = 1'b0; e_mreq = 1'b0;
        if (m_phase == 0) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && bus.c_req[(m_next + k) % 4]) begin
                    w = (m_next + k) % 4;
                    found = 1'b1;
                end
            end
            if (found) begin
                model_grant(w);
                m_txn_in_burst = 1;
            end
        end else if (m_phase == 1) begin
            m_phase  = 2;
            m_waited = 0;
        end else begin
            if (bus.m_rvalid) begin
                e_rvalid = 4'b0001 << m_owner;
                e_rdata  = bus.m_rdata;
                if (bus.c_lock[m_owner] && bus.c_req[m_owner] && m_txn_in_burst < MB) begin
                    model_grant(m_owner);
                    m_txn_in_burst++;
                end else begin
                    model_finish();
                end
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    e_err    = 1'b1;
                    e_rvalid = 4'b0001 << m_owner;
                    e_rdata  = 32'h0;
                    model_finish();
                end
            end
        end
        e_busy = (m_phase != 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("c_gnt", 32'(bus.c_gnt), 32'(e_gnt));
                check("c_rvalid", 32'(bus.c_rvalid), 32'(e_rvalid));
                if (e_rvalid != 0) check("c_rdata", bus.c_rdata, e_rdata);
                check("m_req", 32'(bus.m_req), 32'(e_mreq));
                check("m_we", 32'(bus.m_we), 32'(e_we));
                check("m_core_id", 32'(bus.m_core_id), 32'(e_core));
                check("m_opcode", 32'(bus.m_opcode), 32'(e_op));
                check("m_addr", 32'(bus.m_addr), 32'(e_addr));
                check("m_wdata", bus.m_wdata, e_wdata);
                check("m_burst_id", bus.m_burst_id, e_bid);
                check("busy", 32'(bus.busy), 32'(e_busy));
                check("err", 32'(bus.err), 32'(e_err));
                check("gnt_onehot0", 32'($onehot0(bus.c_gnt)), 32'd1);
                check("rvalid_onehot0", 32'($onehot0(bus.c_rvalid)), 32'd1);
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int pend;
        logic [31:0] pend_data, out_data;
        logic rv;
        pend = -1;
        pend_data = '0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        bus.m_gnt    = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            rv = 1'b0;
            out_data = $urandom;
            if (!reset_n) begin
                pend = -1;
            end else begin
                if (pend == 0) begin
                    rv = 1'b1;
                    out_data = pend_data;
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end
                if (bus.m_req) begin
                    if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
                    pend_data = mem[bus.m_addr];
                    if (rsp_mode == RSP_ZERO) pend = 0;
                    else if (rsp_mode == RSP_NEVER) pend = -1;
                    else pend = ($urandom_range(15) == 0) ? -1 : int'($urandom_range(3));
                end
                if (rsp_mode == RSP_RAND && $urandom_range(31) == 0) rv = 1'b1;
            end
            bus.m_rvalid = rv | force_rv;
            bus.m_rdata  = out_data;
            bus.m_gnt    = $urandom_range(1) == 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        bus.c_req = '0; bus.c_we = '0; bus.c_lock = '0;
        bus.c_addr = '0; bus.c_wdata = '0; bus.c_opcode = '0; bus.c_burst_id = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int err_cyc, n_first, after_core;
        int gq[$];
        reset_n = 1'b0;
        clear_inputs();
        for (int a = 0; a < 2048; a++) mem[a] = $urandom;

        // Reset state
        do_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_m_req", 32'(bus.m_req), 32'd0);
        check("reset_c_gnt", 32'(bus.c_gnt), 32'd0);

        // Core 2 writes 0x05A then reads it back
        do_reset();
        rsp_mode = RSP_ZERO;
        bus.c_req = 4'b0100; bus.c_we = 4'b0100;
        bus.c_addr[22 +: 11] = 11'h05A;
        bus.c_wdata[64 +: 32] = 32'hCAFE_0001;
        bus.c_opcode[8 +: 4] = 4'h3;
        @(negedge clk);
        check("wr_gnt_c1", 32'(bus.c_gnt), 32'h4);
        check("wr_mreq_c1", 32'(bus.m_req), 32'd1);
        check("wr_core_id", 32'(bus.m_core_id), 32'd2);
        check("wr_addr", 32'(bus.m_addr), 32'h05A);
        check("wr_wdata", bus.m_wdata, 32'hCAFE_0001);
        #1;
        bus.c_we = 4'b0000;
        bus.c_wdata[64 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("latched_we", 32'(bus.m_we), 32'd1);
        check("latched_wdata", bus.m_wdata, 32'hCAFE_0001);
        @(negedge clk);
        check("wr_rvalid_c3", 32'(bus.c_rvalid), 32'h4);
        @(negedge clk);
        check("rd_gnt_c4", 32'(bus.c_gnt), 32'h4);
        check("rd_we_c4", 32'(bus.m_we), 32'd0);
        #1 bus.c_req = 4'b0000;
        repeat (2) @(negedge clk);
        check("rd_rvalid_c6", 32'(bus.c_rvalid), 32'h4);
        check("rd_rdata_c6", bus.c_rdata, 32'hCAFE_0001);

        // All four requesting, no lock: 0,1,2,3,0 three cycles apart
        do_reset();
        bus.c_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_order", 32'(bus.c_gnt), 32'(4'b0001 << (k % 4)));
            repeat (2) @(negedge clk);
        end
        #1 bus.c_req = 4'b0000;
        step(4);

        // Locked burst by core 1 with core 3 waiting
        do_reset();
        bus.c_req = 4'b1010; bus.c_lock = 4'b0010;
        for (int c = 1; c <= 40 && gq.size() < 9; c++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (bus.c_gnt[j]) gq.push_back(j);
        end
        n_first = 0;
        while (n_first < gq.size() && gq[n_first] == 1) n_first++;
        after_core = (gq.size() > 8) ? gq[8] : 99;
        check("lock_burst_len", 32'(n_first), 32'd8);
        check("after_burst_core", 32'(after_core), 32'd3);
        #1 clear_inputs();
        step(6);

        // Memory never answers: timeout 15 cycles after entering WAIT
        do_reset();
        rsp_mode = RSP_NEVER;
        bus.c_req = 4'b0001;
        @(negedge clk);
        check("tmo_gnt", 32'(bus.c_gnt), 32'h1);
        #1 bus.c_req = 4'b0000;
        err_cyc = 0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (bus.err) begin
                err_cyc = c;
                break;
            end
        end
        check("tmo_err_cycle", 32'(err_cyc), 32'd17);
        check("tmo_rvalid", 32'(bus.c_rvalid), 32'h1);
        check("tmo_rdata", bus.c_rdata, 32'h0);
        check("tmo_busy", 32'(bus.busy), 32'd0);
        step(2);

        // Reset during WAIT of a core 3 transaction
        do_reset();
        bus.c_req = 4'b1000;
        @(negedge clk);
        check("rst_wait_gnt", 32'(bus.c_gnt), 32'h8);
        #1 bus.c_req = 4'b0000;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        check("rst_async_core", 32'(bus.m_core_id), 32'd0);
        check("rst_async_rvalid", 32'(bus.c_rvalid), 32'd0);
        check("rst_async_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        rsp_mode = RSP_ZERO;
        bus.c_req = 4'b1010;
        @(negedge clk);
        check("rst_restart_gnt", 32'(bus.c_gnt), 32'h2);
        #1 bus.c_req = 4'b0000;
        step(6);

        // Spurious m_rvalid while idle
        do_reset();
        force_rv = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_rv_no_rvalid", 32'(bus.c_rvalid), 32'd0);
            check("idle_rv_busy", 32'(bus.busy), 32'd0);
        end
        #1 force_rv = 1'b0;

        // Randomized traffic
        do_reset();
        rsp_mode = RSP_RAND;
        for (int c = 0; c < 3000; c++) begin
            bus.c_req      = 4'($urandom);
            bus.c_lock     = 4'($urandom) & 4'($urandom);
            bus.c_we       = 4'($urandom);
            bus.c_addr     = 44'({$urandom, $urandom});
            bus.c_wdata    = {$urandom, $urandom, $urandom, $urandom};
            bus.c_opcode   = 16'($urandom);
            bus.c_burst_id = {$urandom, $urandom, $urandom, $urandom};
            step(1);
        end
        clear_inputs();
        rsp_mode = RSP_ZERO;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
